mem_access_unit: RTL and testbench

Memory stage of the five-stage RISC-V pipeline, directly downstream of the execute stage. It takes the ALU result as the effective address and the forwarded rs2 value as store data, and runs loads and stores over a req/ack data-memory bus. It stalls the pipeline while an access is outstanding, and formats load data by width and sign. Its EX/MEM pipeline register feeds write-back and is also the source of the MEM-stage forwarding value.

---
 rtl/mem_access_unit.sv | 241 ++++++++++++++++++++++++
 tb/tb_mem_access_unit.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM stage of the 5-stage RISC-V pipeline.
// Runs loads/stores over a req/ack data bus, stalls the front of the pipe
// while an access is in flight, formats load data and holds the EX/MEM
// pipeline register. Optional feature macro: MEM_MISALIGN_TRAP_EN (flag
// misaligned accesses instead of rounding the address down).
module mem_access_unit #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] ALU_OUT_EX,
    input  logic [31:0] REG_DATA2_EX_FINAL,
    input  logic [2:0]  FUNCT3_EX,
    input  logic [4:0]  RD_EX,
    input  logic        RegWrite_EX,
    input  logic        MemtoReg_EX,
    input  logic        MemRead_EX,
    input  logic        MemWrite_EX,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    output logic        STALL_MEM,
    output logic [31:0] ALU_OUT_MEM,
    output logic [31:0] READ_DATA_MEM,
    output logic [4:0]  RD_MEM,
    output logic        RegWrite_MEM,
    output logic        MemtoReg_MEM,
    output logic        MISALIGN_MEM,
    output logic        BUS_ERR_MEM
);
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    // Last BUSY cycle index before the access is abandoned.
    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    // Everything the bus needs, latched once so it stays stable under req.
    typedef struct packed {
        logic [31:0] addr;   // word aligned
        logic        we;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic [1:0]  ofs;    // byte offset used to pick the load lane
        logic [1:0]  size;
        logic        uns;
    } bus_req_t;

    state_t      state_q, state_d;
    bus_req_t    req_q, req_d, req_ex;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d, rdata_fmt;
    logic        abort_q, abort_d;
    logic        mem_op, trap, stall;
    logic [7:0]  ld_b;
    logic [15:0] ld_h;

    logic [31:0] alu_mem_q, alu_mem_d, rdm_q, rdm_d;
    logic [4:0]  rd_mem_q, rd_mem_d;
    logic        rw_mem_q, rw_mem_d, m2r_mem_q, m2r_mem_d;
    logic        mis_mem_q, mis_mem_d, berr_mem_q, berr_mem_d;

    assign mem_op = MemRead_EX | MemWrite_EX;

    // Decode the EX instruction into a lane-aligned bus request.
    always_comb begin
        req_ex      = '0;
        req_ex.size = FUNCT3_EX[1] ? SZ_W : (FUNCT3_EX[0] ? SZ_H : SZ_B);
        req_ex.uns  = FUNCT3_EX[2];
        req_ex.we   = MemWrite_EX;
        req_ex.addr = {ALU_OUT_EX[31:2], 2'b00};
        case (req_ex.size)
            SZ_B: begin
                req_ex.ofs   = ALU_OUT_EX[1:0];
                req_ex.be    = 4'b0001 << ALU_OUT_EX[1:0];
                req_ex.wdata = {4{REG_DATA2_EX_FINAL[7:0]}};
            end
            SZ_H: begin
                // Rounds a misaligned half down to its even address.
                req_ex.ofs   = {ALU_OUT_EX[1], 1'b0};
                req_ex.be    = ALU_OUT_EX[1] ? 4'b1100 : 4'b0011;
                req_ex.wdata = {2{REG_DATA2_EX_FINAL[15:0]}};
            end
            default: begin
                req_ex.ofs   = 2'b00;
                req_ex.be    = 4'b1111;
                req_ex.wdata = REG_DATA2_EX_FINAL;
            end
        endcase
        if (!MemWrite_EX) req_ex.be = 4'b1111;
    end

`ifdef MEM_MISALIGN_TRAP_EN
    // Misaligned accesses skip the bus and are flagged down the pipe.
    always_comb begin
        trap = 1'b0;
        if (req_ex.size == SZ_H)      trap = mem_op & ALU_OUT_EX[0];
        else if (req_ex.size == SZ_W) trap = mem_op & (|ALU_OUT_EX[1:0]);
    end
`else
    assign trap = 1'b0;
`endif

    // Pick the addressed lane of the bus word and extend it.
    always_comb begin
        ld_b = 8'h00;
        case (req_q.ofs)
            2'd0:    ld_b = mem_rdata[7:0];
            2'd1:    ld_b = mem_rdata[15:8];
            2'd2:    ld_b = mem_rdata[23:16];
            default: ld_b = mem_rdata[31:24];
        endcase
        ld_h      = req_q.ofs[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        rdata_fmt = mem_rdata;
        case (req_q.size)
            SZ_B:    rdata_fmt = {{24{ld_b[7] & ~req_q.uns}}, ld_b};
            SZ_H:    rdata_fmt = {{16{ld_h[15] & ~req_q.uns}}, ld_h};
            default: rdata_fmt = mem_rdata;
        endcase
    end

    // Access FSM: IDLE launches, BUSY waits for ack or timeout, DONE releases.
    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        abort_d = abort_q;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op && !trap) begin
                    stall   = 1'b1;
                    req_d   = req_ex;
                    cnt_d   = 8'd0;
                    rdata_d = 32'd0;
                    abort_d = 1'b0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                stall = 1'b1;
                if (mem_ack) begin
                    rdata_d = rdata_fmt;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q == WAIT_LAST) begin
                        abort_d = 1'b1;
                        state_d = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM and latched bus request.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            req_q   <= '0;
            cnt_q   <= 8'd0;
            rdata_q <= 32'd0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            abort_q <= abort_d;
        end
    end

    // EX/MEM register: load when not stalled, otherwise bubble the controls.
    always_comb begin
        alu_mem_d  = alu_mem_q;
        rdm_d      = rdm_q;
        rd_mem_d   = rd_mem_q;
        rw_mem_d   = 1'b0;
        m2r_mem_d  = 1'b0;
        mis_mem_d  = 1'b0;
        berr_mem_d = 1'b0;
        if (!stall) begin
            alu_mem_d = ALU_OUT_EX;
            rd_mem_d  = RD_EX;
            m2r_mem_d = MemtoReg_EX;
            if (state_q == DONE) begin
                rdm_d      = (abort_q || req_q.we) ? 32'd0 : rdata_q;
                rw_mem_d   = RegWrite_EX & ~abort_q;
                berr_mem_d = abort_q;
            end else begin
                rdm_d     = 32'd0;
                rw_mem_d  = RegWrite_EX & ~trap;
                mis_mem_d = trap;
            end
        end
    end

    // EX/MEM pipeline register state.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            alu_mem_q  <= 32'd0;
            rdm_q      <= 32'd0;
            rd_mem_q   <= 5'd0;
            rw_mem_q   <= 1'b0;
            m2r_mem_q  <= 1'b0;
            mis_mem_q  <= 1'b0;
            berr_mem_q <= 1'b0;
        end else begin
            alu_mem_q  <= alu_mem_d;
            rdm_q      <= rdm_d;
            rd_mem_q   <= rd_mem_d;
            rw_mem_q   <= rw_mem_d;
            m2r_mem_q  <= m2r_mem_d;
            mis_mem_q  <= mis_mem_d;
            berr_mem_q <= berr_mem_d;
        end
    end

    assign mem_req       = (state_q == BUSY);
    assign mem_we        = req_q.we;
    assign mem_addr      = req_q.addr;
    assign mem_be        = req_q.be;
    assign mem_wdata     = req_q.wdata;
    assign STALL_MEM     = stall;
    assign ALU_OUT_MEM   = alu_mem_q;
    assign READ_DATA_MEM = rdm_q;
    assign RD_MEM        = rd_mem_q;
    assign RegWrite_MEM  = rw_mem_q;
    assign MemtoReg_MEM  = m2r_mem_q;
    assign MISALIGN_MEM  = mis_mem_q;
    assign BUS_ERR_MEM   = berr_mem_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected write-back records are
// queued when an instruction is driven and popped when it leaves MEM.
module tb_mem_access_unit;
    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] ALU_OUT_EX, REG_DATA2_EX_FINAL, mem_rdata;
    logic [2:0]  FUNCT3_EX;
    logic [4:0]  RD_EX;
    logic        RegWrite_EX, MemtoReg_EX, MemRead_EX, MemWrite_EX, mem_ack;
    logic        mem_req, mem_we, STALL_MEM;
    logic [31:0] mem_addr, mem_wdata, ALU_OUT_MEM, READ_DATA_MEM;
    logic [3:0]  mem_be;
    logic [4:0]  RD_MEM;
    logic        RegWrite_MEM, MemtoReg_MEM, MISALIGN_MEM, BUS_ERR_MEM;

    mem_access_unit #(.MAX_WAIT(15)) dut (
        .clk(clk), .reset_n(reset_n),
        .ALU_OUT_EX(ALU_OUT_EX), .REG_DATA2_EX_FINAL(REG_DATA2_EX_FINAL),
        .FUNCT3_EX(FUNCT3_EX), .RD_EX(RD_EX),
        .RegWrite_EX(RegWrite_EX), .MemtoReg_EX(MemtoReg_EX),
        .MemRead_EX(MemRead_EX), .MemWrite_EX(MemWrite_EX),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .STALL_MEM(STALL_MEM),
        .ALU_OUT_MEM(ALU_OUT_MEM), .READ_DATA_MEM(READ_DATA_MEM),
        .RD_MEM(RD_MEM), .RegWrite_MEM(RegWrite_MEM),
        .MemtoReg_MEM(MemtoReg_MEM), .MISALIGN_MEM(MISALIGN_MEM),
        .BUS_ERR_MEM(BUS_ERR_MEM)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] alu;
        logic [31:0] rdata;
        logic [4:0]  rd;
        logic        rw, m2r, mis, berr;
    } wb_t;

    wb_t exp_q[$];
    int  n_cmp = 0;
    int  n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic wb_t wb(input logic [31:0] alu, input logic [31:0] rdata,
                               input logic [4:0] rd, input logic rw, input logic m2r,
                               input logic mis, input logic berr);
        wb_t r;
        r.alu = alu; r.rdata = rdata; r.rd = rd;
        r.rw = rw; r.m2r = m2r; r.mis = mis; r.berr = berr;
        return r;
    endfunction

    // Drive one EX instruction, answer the bus after ack_dly wait cycles
    // (negative: never), and score its MEM-stage result.
    task automatic run_op(input string nm, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] sdata, input logic [4:0] rd,
                          input logic rw, input logic m2r, input logic mr, input logic mw,
                          input int ack_dly, input logic [31:0] rdata,
                          input logic [31:0] x_addr, input logic [3:0] x_be,
                          input logic [31:0] x_wdata, input int x_busy, input int x_stall,
                          input wb_t x_wb);
        int   busy = 0;
        int   stalls = 0;
        bit   done = 1'b0;
        logic stall_now;
        wb_t  e;
        ALU_OUT_EX = addr; REG_DATA2_EX_FINAL = sdata; FUNCT3_EX = f3; RD_EX = rd;
        RegWrite_EX = rw; MemtoReg_EX = m2r; MemRead_EX = mr; MemWrite_EX = mw;
        exp_q.push_back(x_wb);
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            #1;
            if (mem_req) begin
                busy++;
                mem_ack   = (ack_dly >= 0) && (busy > ack_dly);
                mem_rdata = rdata;
                chk({nm, "_addr"}, mem_addr, x_addr);
                chk({nm, "_be"}, 32'(mem_be), 32'(x_be));
                chk({nm, "_we"}, 32'(mem_we), 32'(mw));
                if (mw) chk({nm, "_wdata"}, mem_wdata, x_wdata);
            end else begin
                mem_ack   = 1'b0;
                mem_rdata = 32'hDEAD_0000;
            end
            #1;
            stall_now = STALL_MEM;
            @(posedge clk);
            #1;
            if (stall_now) begin
                stalls++;
                chk({nm, "_bubble_rw"}, 32'(RegWrite_MEM), 32'd0);
            end else begin
                done = 1'b1;
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk({nm, "_alu"}, ALU_OUT_MEM, e.alu);
                    chk({nm, "_rdata"}, READ_DATA_MEM, e.rdata);
                    chk({nm, "_rd"}, 32'(RD_MEM), 32'(e.rd));
                    chk({nm, "_rw"}, 32'(RegWrite_MEM), 32'(e.rw));
                    chk({nm, "_m2r"}, 32'(MemtoReg_MEM), 32'(e.m2r));
                    chk({nm, "_mis"}, 32'(MISALIGN_MEM), 32'(e.mis));
                    chk({nm, "_berr"}, 32'(BUS_ERR_MEM), 32'(e.berr));
                end
            end
            @(negedge clk);
        end
        mem_ack = 1'b0;
        chk({nm, "_done"}, 32'(done), 32'd1);
        chk({nm, "_busy"}, 32'(busy), 32'(x_busy));
        chk({nm, "_stall"}, 32'(stalls), 32'(x_stall));
    endtask

    task automatic ex_nop();
        ALU_OUT_EX = 0; REG_DATA2_EX_FINAL = 0; FUNCT3_EX = 0; RD_EX = 0;
        RegWrite_EX = 0; MemtoReg_EX = 0; MemRead_EX = 0; MemWrite_EX = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0; ex_nop(); mem_ack = 1'b0; mem_rdata = 32'd0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req", 32'(mem_req), 32'd0);
        chk("rst_stall", 32'(STALL_MEM), 32'd0);
        chk("rst_alu", ALU_OUT_MEM, 32'd0);
        chk("rst_rdata", READ_DATA_MEM, 32'd0);
        chk("rst_rw", 32'(RegWrite_MEM), 32'd0);
        chk("rst_berr", 32'(BUS_ERR_MEM), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        run_op("sw", 3'b010, 32'h100, 32'hDEADBEEF, 5'd0, 0, 0, 0, 1, 0, 32'h0,
               32'h100, 4'b1111, 32'hDEADBEEF, 1, 2, wb(32'h100, 32'h0, 5'd0, 0, 0, 0, 0));
        run_op("lb", 3'b000, 32'h103, 32'h0, 5'd5, 1, 1, 1, 0, 0, 32'h80FFFF7F,
               32'h100, 4'b1111, 32'h0, 1, 2, wb(32'h103, 32'hFFFFFF80, 5'd5, 1, 1, 0, 0));
        run_op("lbu", 3'b100, 32'h103, 32'h0, 5'd6, 1, 1, 1, 0, 0, 32'h80FFFF7F,
               32'h100, 4'b1111, 32'h0, 1, 2, wb(32'h103, 32'h00000080, 5'd6, 1, 1, 0, 0));
        run_op("sh", 3'b001, 32'h202, 32'h00001234, 5'd0, 0, 0, 0, 1, 4, 32'h0,
               32'h200, 4'b1100, 32'h12341234, 5, 6, wb(32'h202, 32'h0, 5'd0, 0, 0, 0, 0));
        run_op("lw_to", 3'b010, 32'h300, 32'h0, 5'd9, 1, 1, 1, 0, -1, 32'h5555AAAA,
               32'h300, 4'b1111, 32'h0, 15, 16, wb(32'h300, 32'h0, 5'd9, 0, 1, 0, 1));
        run_op("add", 3'b000, 32'h77, 32'h0, 5'd3, 1, 0, 0, 0, 0, 32'h0,
               32'h0, 4'h0, 32'h0, 0, 0, wb(32'h77, 32'h0, 5'd3, 1, 0, 0, 0));
        run_op("lh", 3'b001, 32'h106, 32'h0, 5'd10, 1, 1, 1, 0, 2, 32'h80011234,
               32'h104, 4'b1111, 32'h0, 3, 4, wb(32'h106, 32'hFFFF8001, 5'd10, 1, 1, 0, 0));
        run_op("lhu", 3'b101, 32'h106, 32'h0, 5'd11, 1, 1, 1, 0, 0, 32'h80011234,
               32'h104, 4'b1111, 32'h0, 1, 2, wb(32'h106, 32'h00008001, 5'd11, 1, 1, 0, 0));
        run_op("sb", 3'b000, 32'h101, 32'h000000AB, 5'd0, 0, 0, 0, 1, 1, 32'h0,
               32'h100, 4'b0010, 32'hABABABAB, 2, 3, wb(32'h101, 32'h0, 5'd0, 0, 0, 0, 0));
`ifdef MEM_MISALIGN_TRAP_EN
        run_op("lw_mis", 3'b010, 32'h102, 32'h0, 5'd7, 1, 1, 1, 0, 0, 32'h11223344,
               32'h0, 4'h0, 32'h0, 0, 0, wb(32'h102, 32'h0, 5'd7, 0, 1, 1, 0));
`else
        run_op("lw_mis", 3'b010, 32'h102, 32'h0, 5'd7, 1, 1, 1, 0, 0, 32'h11223344,
               32'h100, 4'b1111, 32'h0, 1, 2, wb(32'h102, 32'h11223344, 5'd7, 1, 1, 0, 0));
`endif
        run_op("add2", 3'b000, 32'h1234, 32'h0, 5'd4, 1, 0, 0, 0, 0, 32'h0,
               32'h0, 4'h0, 32'h0, 0, 0, wb(32'h1234, 32'h0, 5'd4, 1, 0, 0, 0));

        // Reset in the middle of an unacknowledged load.
        ALU_OUT_EX = 32'h400; FUNCT3_EX = 3'b010; RD_EX = 5'd12;
        RegWrite_EX = 1; MemtoReg_EX = 1; MemRead_EX = 1; MemWrite_EX = 0;
        mem_ack = 1'b0;
        @(posedge clk); @(posedge clk); @(negedge clk);
        #1;
        chk("mid_req", 32'(mem_req), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        chk("arst_req", 32'(mem_req), 32'd0);
        chk("arst_addr", mem_addr, 32'd0);
        chk("arst_be", 32'(mem_be), 32'd0);
        chk("arst_alu", ALU_OUT_MEM, 32'd0);
        chk("arst_rd", 32'(RD_MEM), 32'd0);
        chk("arst_rw", 32'(RegWrite_MEM), 32'd0);
        ex_nop();
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run_op("add_rst", 3'b000, 32'h5, 32'h0, 5'd1, 1, 0, 0, 0, 0, 32'h0,
               32'h0, 4'h0, 32'h0, 0, 0, wb(32'h5, 32'h0, 5'd1, 1, 0, 0, 0));

        chk("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
